// File: rtl/sram_mem_responder_if.sv
// rtl/sram_mem_responder_if.sv - request/response bus between LC-3 control/datapath and the memory responder
//
// Signals:
//   Mem_Req    request strobe, sampled by the responder only while idle
//   Mem_WE     1 = write, 0 = read; latched together with Mem_Req
//   MAR        request address
//   MDR        write data
//   MDR_In     read data returned to the datapath
//   Mem_Ready  one-cycle completion pulse
// Modports: master = control/datapath side, slave = responder side.

interface sram_mem_responder_if;
  logic        Mem_Req;
  logic        Mem_WE;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] MDR_In;
  logic        Mem_Ready;

  modport master (
    output Mem_Req, Mem_WE, MAR, MDR,
    input  MDR_In, Mem_Ready
  );

  modport slave (
    input  Mem_Req, Mem_WE, MAR, MDR,
    output MDR_In, Mem_Ready
  );
endinterface

// File: rtl/sram_mem_responder.sv
// rtl/sram_mem_responder.sv - LC-3 memory request responder driving an external 16-bit SRAM
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   mem (slave)         Mem_Req/Mem_WE/MAR/MDR in, MDR_In/Mem_Ready out
//   SRAM_ADDR           SRAM address, bits above 15 driven 0
//   SRAM_*_N            CE/OE/WE/UB/LB strobes, active-low
//   SRAM_DQ_In/Out/OE   split SRAM data bus; the pad tristate lives at top level
//   Switches            board switches (read at 0xFFFF with IO_MAP_EN)
//   Hex_Data            memory-mapped hex display register (0 without IO_MAP_EN)
// Build option: define IO_MAP_EN to map address 0xFFFF to Switches/Hex_Data.
// Parameters: WAIT_CYCLES (ACCESS cycles, <1 treated as 1), ADDR_W (SRAM address width).

module sram_mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_mem_responder_if.slave mem,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  input  logic [15:0]       SRAM_DQ_In,
  output logic [15:0]       SRAM_DQ_Out,
  output logic              SRAM_DQ_OE,
  input  logic [15:0]       Switches,
  output logic [15:0]       Hex_Data
);

  localparam int WC    = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CNT_W = $clog2(WC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        addr_q, wdata_q, rdata_q;
  logic               we_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_access;
  logic               io_hit;

  assign last_access = (state_q == ACCESS) && (cnt_q == CNT_W'(1));

`ifdef IO_MAP_EN
  assign io_hit = (addr_q == 16'hFFFF);
`else
  assign io_hit = 1'b0;
  logic unused_switches;
  assign unused_switches = ^Switches;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && mem.Mem_Req) begin
        addr_q  <= mem.MAR;
        wdata_q <= mem.MDR;
        we_q    <= mem.Mem_WE;
      end
      if (state_q == SETUP)
        cnt_q <= CNT_W'(WC);
      else if (state_q == ACCESS)
        cnt_q <= cnt_q - CNT_W'(1);
      // Read data is sampled at the end of the access window, when the SRAM output is settled.
      if (last_access && !we_q) begin
`ifdef IO_MAP_EN
        rdata_q <= io_hit ? Switches : SRAM_DQ_In;
`else
        rdata_q <= SRAM_DQ_In;
`endif
      end
    end
  end

`ifdef IO_MAP_EN
  always_ff @(posedge Clk) begin
    if (Reset)
      Hex_Data <= '0;
    else if (last_access && we_q && io_hit)
      Hex_Data <= wdata_q;
  end
`else
  assign Hex_Data = '0;
`endif

  always_comb begin
    state_d     = state_q;
    SRAM_CE_N   = 1'b1;
    SRAM_OE_N   = 1'b1;
    SRAM_WE_N   = 1'b1;
    SRAM_UB_N   = 1'b1;
    SRAM_LB_N   = 1'b1;
    SRAM_DQ_OE  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem.Mem_Req) state_d = SETUP;
      end
      SETUP, ACCESS: begin
        if (state_q == SETUP) state_d = ACCESS;
        else if (last_access) state_d = DONE;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        if (!io_hit) begin
          SRAM_CE_N = 1'b0;
          if (we_q) begin
            SRAM_DQ_OE = 1'b1;
            // WE_N falls only after a full SETUP cycle so address/data are stable first.
            SRAM_WE_N  = (state_q == SETUP);
          end else begin
            SRAM_OE_N  = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        // Writes keep CE and the data driver on one more cycle after WE_N rises (data hold).
        if (we_q) begin
          SRAM_UB_N = 1'b0;
          SRAM_LB_N = 1'b0;
          if (!io_hit) begin
            SRAM_CE_N  = 1'b0;
            SRAM_DQ_OE = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign SRAM_ADDR     = ADDR_W'(addr_q);
  assign SRAM_DQ_Out   = wdata_q;
  assign mem.MDR_In    = rdata_q;
  assign mem.Mem_Ready = (state_q == DONE);

endmodule

// File: doc/sram_mem_responder.md
Name: sram_mem_responder

Overview:
Memory-side responder for the LC-3 datapath's memory requests. It accepts a read or write request built from MAR/MDR, runs a multi-cycle SRAM access with fixed wait states, and returns read data on MDR_In with a one-cycle Mem_Ready pulse. It sits between the control/datapath and the external 16-bit SRAM. SRAM data is split into separate in, out and output-enable signals; the tristate is resolved at top level.

Parameters:
WAIT_CYCLES, 2, number of ACCESS-state cycles (values <1 behave as 1)
ADDR_W, 20, SRAM address width; upper bits above 16 are driven 0

Ports:
Clk  in  1  clock
Reset  in  1  synchronous active-high reset
Mem_Req  in  1  request strobe from control, sampled in IDLE
Mem_WE  in  1  1 = write, 0 = read; latched with Mem_Req
MAR  in  16  request address
MDR  in  16  write data
MDR_In  out  16  read data returned to datapath
Mem_Ready  out  1  one-cycle completion pulse
SRAM_ADDR  out  ADDR_W  SRAM address
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM controls, active-low
SRAM_DQ_In  in  16  data from SRAM
SRAM_DQ_Out  out  16  data to SRAM
SRAM_DQ_OE  out  1  1 = drive SRAM_DQ_Out onto the pad
Switches  in  16  board switches (used only under IO_MAP_EN)
Hex_Data  out  16  memory-mapped hex display register

Behaviour:
- Interface: reset Reset, synchronous, active-high; clock Clk.
- FSM has four states: IDLE, SETUP, ACCESS, DONE. Outputs are Moore-decoded from registered state and registered data.
- Reset values: state=IDLE. All *_N=1. SRAM_DQ_OE=0. SRAM_ADDR=0. SRAM_DQ_Out=0. MDR_In=0. Mem_Ready=0. Hex_Data=0. Wait counter=0.
- IDLE: if Mem_Req=1, latch addr_q<=MAR, wdata_q<=MDR, we_q<=Mem_WE, then go to SETUP. Otherwise stay in IDLE.
- SETUP, 1 cycle:
  - SRAM_ADDR={0,addr_q}. CE_N=0, UB_N=LB_N=0.
  - Write: DQ_OE=1, DQ_Out=wdata_q, WE_N=1.
  - Read: OE_N=0.
  - Load counter with WAIT_CYCLES, then go to ACCESS.
- ACCESS, WAIT_CYCLES cycles: controls held as in SETUP, except WE_N=0 for writes. On the last ACCESS cycle, a read captures rdata_q<=SRAM_DQ_In. Then go to DONE.
- DONE, 1 cycle:
  - Mem_Ready=1.
  - Write: WE_N=1, CE_N=0, DQ_OE=1 (data hold).
  - Read: OE_N=1.
  - Always go to IDLE.
- MDR_In=rdata_q. It holds its value until the next read completes; writes do not change it.
- Latency: Mem_Req high in IDLE cycle t gives Mem_Ready high in cycle t+2+WAIT_CYCLES.
- Mem_Req still high on return to IDLE starts a new transaction. Back-to-back period is 3+WAIT_CYCLES cycles.
- MAR/MDR/Mem_WE changes after the latch cycle are ignored until the next IDLE.
- DQ_OE and OE_N are never both active in the same cycle.
- Reset mid-operation: next cycle is IDLE with all reset values. An in-flight write is aborted and that SRAM word is undefined. An in-flight read leaves MDR_In=0.

Optional Feature:
IO_MAP_EN
- Defined: address 0xFFFF is memory-mapped I/O and keeps the same FSM timing.
  - CE_N, OE_N and WE_N stay 1 and DQ_OE stays 0 for the whole transaction.
  - Read: rdata_q<=Switches on the last ACCESS cycle.
  - Write: Hex_Data<=wdata_q on entering DONE.
- Undefined: 0xFFFF is an ordinary SRAM address. Hex_Data is constant 0 and Switches is ignored.

Test Plan:
- Reset, then write MDR=0x1234 to MAR=0x0042 (WAIT_CYCLES=2) -> SRAM_ADDR=0x00042; WE_N low exactly 2 cycles with DQ_Out=0x1234; DQ_OE=1 from SETUP through DONE; Mem_Ready pulses 4 cycles after request.
- Read MAR=0x0042 with SRAM model returning 0x1234 -> OE_N low SETUP..ACCESS; WE_N never low; MDR_In=0x1234 in DONE, held after.
- Change MAR to 0x0100 and MDR to 0xFFFF during ACCESS of a write to 0x0042 -> SRAM_ADDR stays 0x00042 and DQ_Out stays 0x1234.
- Assert Reset in the second ACCESS cycle of a write -> next cycle all *_N=1, DQ_OE=0, Mem_Ready=0; a following read of 0x0010 completes normally in 4 cycles.
- Hold Mem_Req=1 continuously with alternating Mem_WE -> Mem_Ready pulses every 5 cycles; no cycle has DQ_OE=1 and OE_N=0 together.
- IO_MAP_EN defined: Switches=0xBEEF, read 0xFFFF -> MDR_In=0xBEEF and CE_N stays 1; write 0x00AA to 0xFFFF -> Hex_Data=0x00AA from DONE on. Undefined: the same read drives SRAM_ADDR=0x0FFFF with CE_N=0.
